huffman_bit_feeder: RTL and testbench

- Upstream stage of the serial Huffman decoder.
- Accepts bytes of the Huffman-coded bitstream over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte MSB first, one bit per cycle, into the decoder's single-bit input `e`.
- Supports downstream backpressure and a synchronous flush, used at granule/frame boundaries.

---
 rtl/huffman_bit_feeder_if.sv | 25 ++
 rtl/huffman_bit_feeder.sv | 138 +++++++++++++
 tb/tb_huffman_bit_feeder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/huffman_bit_feeder_if.sv
// Byte-in / bit-out bus between the bitstream source, the bit feeder and the serial Huffman decoder.
// The master side is the producer/consumer environment and the slave side is the feeder itself.
interface huffman_bit_feeder_if #(
    parameter int CNT_W = 16
) ();
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic [CNT_W-1:0] bits_consumed;
    logic             empty;

    modport master (
        output in_data, in_valid, flush, bit_ready,
        input  in_ready, bit_out, bit_valid, bits_consumed, empty
    );

    modport slave (
        input  in_data, in_valid, flush, bit_ready,
        output in_ready, bit_out, bit_valid, bits_consumed, empty
    );
endinterface

// File: rtl/huffman_bit_feeder.sv
// Buffers Huffman bitstream bytes in a small FIFO and serializes them MSB first, one bit per cycle,
// into the decoder input. The byte boundary is seamless when the next byte is already queued.
module huffman_bit_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    huffman_bit_feeder_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] consumed_q, consumed_d;
    logic             in_ready_q, in_ready_d;
    logic             empty_q, empty_d;
    logic             push_s, load_s, take_s, wr_en_s;

    // Next-state logic for FIFO pointers, shifter FSM and the consumed-bit counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        consumed_d = consumed_q;

        take_s  = (state_q == SHIFT) && bus.bit_ready;
        push_s  = bus.in_valid && in_ready_q;
        // A refill uses only the registered occupancy, so a byte pushed this edge waits one cycle.
        load_s  = (count_q != {OCC_W{1'b0}}) &&
                  ((state_q == IDLE) || (take_s && (bit_idx_q == 3'd0)));
        wr_en_s = push_s && !bus.flush;

        if (take_s) begin
            shift_d    = {shift_q[6:0], 1'b0};
            bit_idx_d  = bit_idx_q - 3'd1;
            consumed_d = consumed_q + CNT_W'(1);
            if (bit_idx_q == 3'd0) begin
                state_d = IDLE;
            end else begin
                state_d = SHIFT;
            end
        end else begin
            shift_d    = shift_q;
            bit_idx_d  = bit_idx_q;
            consumed_d = consumed_q;
        end

        if (load_s) begin
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = 3'd7;
            state_d   = SHIFT;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d  = rd_ptr_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, load_s})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.flush) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {OCC_W{1'b0}};
            state_d    = IDLE;
            shift_d    = 8'h00;
            bit_idx_d  = 3'd0;
            consumed_d = {CNT_W{1'b0}};
        end else begin
            consumed_d = consumed_d;
        end

        in_ready_d = (count_d != DEPTH_C);
        empty_d    = (count_d == {OCC_W{1'b0}}) && (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {OCC_W{1'b0}};
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            consumed_q <= {CNT_W{1'b0}};
            in_ready_q <= 1'b1;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            consumed_q <= consumed_d;
            in_ready_q <= in_ready_d;
            empty_q    <= empty_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.bit_out       = shift_q[7];
    assign bus.bit_valid     = (state_q == SHIFT);
    assign bus.in_ready      = in_ready_q;
    assign bus.empty         = empty_q;
    assign bus.bits_consumed = consumed_q;
endmodule

// File: tb/tb_huffman_bit_feeder.sv
// Self-checking bench for huffman_bit_feeder: directed scenarios plus random traffic, all
// compared every cycle against a byte-queue / bit-queue reference model.
module tb_huffman_bit_feeder;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst;

    huffman_bit_feeder_if #(.CNT_W(CW)) bus ();

    huffman_bit_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit [7:0]    fq[$];
    bit          sq[$];
    int unsigned cnt_m;
    bit          got_q[$];
    bit          saw_wrap;
    logic [CW-1:0] prev_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a queue of whole bytes waiting and a queue of bits left in the current byte.
    task automatic model_edge(input logic r, input logic f, input logic v,
                              input logic [7:0] d, input logic br);
        bit push;
        bit need_load;
        bit [7:0] b;
        if (r || f) begin
            fq.delete();
            sq.delete();
            cnt_m = 0;
        end else begin
            push      = v && (fq.size() < DEPTH);
            need_load = (sq.size() == 0);
            if (sq.size() != 0 && br) begin
                void'(sq.pop_front());
                cnt_m     = (cnt_m + 1) % (1 << CW);
                need_load = (sq.size() == 0);
            end
            if (need_load && fq.size() > 0) begin
                b = fq.pop_front();
                for (int i = 7; i >= 0; i--) sq.push_back(b[i]);
            end
            if (push) fq.push_back(d);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [7:0] d, input logic br);
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.bit_ready = br;
        if (!r && !f && bus.bit_valid === 1'b1 && br) got_q.push_back(bus.bit_out);
        prev_cnt = bus.bits_consumed;
        @(posedge clk);
        model_edge(r, f, v, d, br);
        #1;
        check("bit_valid", bus.bit_valid, sq.size() != 0);
        if (sq.size() != 0) check("bit_out", bus.bit_out, sq[0]);
        check("in_ready", bus.in_ready, fq.size() < DEPTH);
        check("empty", bus.empty, (fq.size() == 0) && (sq.size() == 0));
        check("bits_consumed", bus.bits_consumed, cnt_m);
        if (!r && !f && prev_cnt == {CW{1'b1}} && bus.bits_consumed == {CW{1'b0}}) saw_wrap = 1'b1;
    endtask

    task automatic check_stream(input string tag, input logic [15:0] exp, input int n);
        logic [15:0] val;
        val = 16'h0000;
        check({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < 16; i++) val = {val[14:0], got_q[i]};
        check({tag, "_bits"}, val, exp);
    endtask

    initial begin
        int k;
        logic [7:0] fill_data [6];
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.bit_ready = 1'b0;
        saw_wrap = 1'b0;
        cnt_m = 0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_bit_out", bus.bit_out, 1'b0);

        // Single byte, MSB first.
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1, 8'hB4, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("b4_latency", bus.bit_valid, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_stream("b4", 16'h00B4, 8);
        check("b4_count", bus.bits_consumed, 8);
        check("b4_empty", bus.empty, 1'b1);

        // Back-to-back bytes with no bubble.
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_stream("ff00", 16'hFF00, 16);

        // Fill under backpressure: six bytes offered, producer holds until accepted.
        for (int i = 0; i < 6; i++) fill_data[i] = 8'(8'h10 + 8'(i));
        k = 0;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            acc = (k < 6) && (bus.in_ready === 1'b1);
            cycle(1'b0, 1'b0, k < 6, fill_data[k < 6 ? k : 5], 1'b0);
            if (acc) k++;
        end
        check("fill_accepted", k, 5);
        check("fill_full", bus.in_ready, 1'b0);
        for (int c = 0; c < 60; c++) begin
            logic acc;
            acc = (k < 6) && (bus.in_ready === 1'b1);
            cycle(1'b0, 1'b0, k < 6, fill_data[k < 6 ? k : 5], 1'b1);
            if (acc) k++;
        end
        check("fill_all", k, 6);

        // Alternating backpressure.
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'(i % 2));
        check_stream("a5", 16'h00A5, 8);

        // Flush mid-byte with a concurrent write and transfer.
        cycle(1'b0, 1'b0, 1'b1, 8'hF0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
        check("flush_valid", bus.bit_valid, 1'b0);
        check("flush_empty", bus.empty, 1'b1);
        check("flush_count", bus.bits_consumed, 0);
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_stream("post_flush", 16'h0080, 8);

        // Reset during SHIFT with flush and a write pending.
        cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h6B, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_mid_empty", bus.empty, 1'b1);
        check("rst_mid_count", bus.bits_consumed, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            cycle(1'b0, $urandom_range(0, 63) == 0, 1'($urandom % 2),
                  8'($urandom), $urandom_range(0, 3) != 0);
        end

        // Counter wrap: stream more than 2^CW bits without flush.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        saw_wrap = 1'b0;
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
        check("wrap_seen", saw_wrap, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
